// File: rtl/input_conditioner.sv
// Switch/key input conditioner: two-flop synchronizer, four-state debounce FSM,
// edge pulses, a toggle level and a modulo-256 count of accepted rising edges.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       D_raw,
  output logic       Q,
  output logic       Rise,
  output logic       Fall,
  output logic       Toggle,
  output logic [7:0] Count
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             toggle_q, toggle_d;
  logic [7:0]       count_q, count_d;

  always_comb begin
    sync1_d = D_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so Q moves on the accepting edge.
    q_d      = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
    rise_d   = q_d & ~q_q;
    fall_d   = ~q_d & q_q;
    toggle_d = toggle_q ^ rise_d;
    count_d  = count_q + {7'd0, rise_d};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE_LOW;
      cnt_q    <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      q_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      count_q  <= count_d;
    end
  end

  assign Q      = q_q;
  assign Rise   = rise_q;
  assign Fall   = fall_q;
  assign Toggle = toggle_q;
  assign Count  = count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4; expected values
// are hand-derived edge counts (Q moves on the 7th edge after D_raw changes).
module tb_input_conditioner;

  logic       Clk;
  logic       Reset;
  logic       D_raw;
  logic       Q;
  logic       Rise;
  logic       Fall;
  logic       Toggle;
  logic [7:0] Count;

  int tests_run = 0;
  int tests_failed = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .D_raw  (D_raw),
    .Q      (Q),
    .Rise   (Rise),
    .Fall   (Fall),
    .Toggle (Toggle),
    .Count  (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press_release();
    D_raw = 1'b1;
    repeat (10) tick();
    D_raw = 1'b0;
    repeat (10) tick();
  endtask

  // Rise and Fall must be mutually exclusive on every cycle.
  always @(negedge Clk) begin
    if (Rise && Fall) check("rise_fall_excl", {31'd0, Rise & Fall}, 32'd0);
  end

  initial begin
    Reset = 1'b1;
    D_raw = 1'b0;
    repeat (2) tick();
    check("rst_q", Q, 0);
    check("rst_rise", Rise, 0);
    check("rst_fall", Fall, 0);
    check("rst_toggle", Toggle, 0);
    check("rst_count", Count, 0);
    Reset = 1'b0;
    tick();

    // Clean press: Q and Rise on edge 7, Rise drops on edge 8.
    $display("[TB] clean press");
    D_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("press_q_early", Q, 0);
    end
    tick();
    check("press_q", Q, 1);
    check("press_rise", Rise, 1);
    check("press_toggle", Toggle, 1);
    check("press_count", Count, 1);
    tick();
    check("press_rise_drop", Rise, 0);
    check("press_q_hold", Q, 1);
    repeat (4) tick();

    // Short low glitch while high is rejected.
    $display("[TB] low glitch");
    D_raw = 1'b0;
    repeat (3) tick();
    D_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("glitch_q", Q, 1);
      check("glitch_fall", Fall, 0);
      check("glitch_rise", Rise, 0);
      tick();
    end
    check("glitch_count", Count, 1);

    // Clean release: Fall on edge 7, Toggle/Count untouched.
    $display("[TB] clean release");
    D_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("release_q_early", Q, 1);
    end
    tick();
    check("release_q", Q, 0);
    check("release_fall", Fall, 1);
    check("release_toggle", Toggle, 1);
    check("release_count", Count, 1);
    tick();
    check("release_fall_drop", Fall, 0);
    repeat (4) tick();

    // Boundary: 4-cycle high pulse is rejected, 5-cycle pulse is accepted.
    $display("[TB] boundary pulses");
    D_raw = 1'b1;
    repeat (4) tick();
    D_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("pulse4_q", Q, 0);
      check("pulse4_rise", Rise, 0);
    end
    check("pulse4_count", Count, 1);
    D_raw = 1'b1;
    repeat (5) tick();
    D_raw = 1'b0;
    repeat (2) tick();
    check("pulse5_q", Q, 1);
    check("pulse5_rise", Rise, 1);
    check("pulse5_count", Count, 2);
    check("pulse5_toggle", Toggle, 0);
    repeat (12) tick();
    check("pulse5_settle_q", Q, 0);

    // Reset mid-debounce (WAIT_HIGH, counter=2) with D_raw held high.
    $display("[TB] reset mid-debounce");
    D_raw = 1'b1;
    repeat (5) tick();
    check("middeb_q_before", Q, 0);
    Reset = 1'b1;
    tick();
    check("middeb_rst_q", Q, 0);
    check("middeb_rst_rise", Rise, 0);
    check("middeb_rst_count", Count, 0);
    check("middeb_rst_toggle", Toggle, 0);
    Reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("middeb_q_early", Q, 0);
    end
    tick();
    check("middeb_q", Q, 1);
    check("middeb_rise", Rise, 1);
    check("middeb_count", Count, 1);
    D_raw = 1'b0;
    repeat (10) tick();

    // Reset on the accepting edge wins over the pending Rise.
    $display("[TB] reset on accept edge");
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    D_raw = 1'b1;
    repeat (6) tick();
    Reset = 1'b1;
    tick();
    check("accrst_q", Q, 0);
    check("accrst_rise", Rise, 0);
    check("accrst_count", Count, 0);
    D_raw = 1'b0;
    tick();
    Reset = 1'b0;
    repeat (3) tick();

    // 256 press/release cycles wrap Count and return Toggle to 0.
    $display("[TB] 256 press/release cycles");
    for (int n = 1; n <= 255; n++) press_release();
    check("wrap_count_255", Count, 255);
    check("wrap_toggle_255", Toggle, 1);
    press_release();
    check("wrap_count", Count, 0);
    check("wrap_toggle", Toggle, 0);
    check("wrap_q", Q, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
